risc_core_param: RTL and testbench

// Parametrised successor to the 8-bit multi-cycle RISC core: same FETCH/DECODE/EXECUTE/WRITE_BACK

---
 rtl/risc_pkg.sv | 48 ++++
 rtl/risc_alu.sv | 46 ++++
 rtl/risc_core_param.sv | 165 ++++++++++++++++
 tb/tb_risc_core_param.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the parametrised multi-cycle RISC core.
//   - opcode values (instruction bits [15:12])
//   - FSM state type
//   - instruction field helpers and opcode classification
package risc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITE_BACK,
    S_HALTED
  } state_t;

  function automatic logic [3:0] instr_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [7:0] instr_imm8(input logic [15:0] ir);
    return ir[7:0];
  endfunction

  // ALU and shift ops: these update the flags
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LD) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu: combinational ALU for the RISC core.
// Ports:
//   op    in  4       opcode (ADD/SUB/AND/OR/XOR/SHL/SHR; others give y=0)
//   a, b  in  DATA_W  operands (shifts use a only)
//   y     out DATA_W  result, modulo 2^DATA_W
//   zero  out 1       y == 0
//   carry out 1       ADD carry-out, SUB borrow, SHL old MSB, SHR old LSB; 0 otherwise
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              carry
);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        y     = a - b;
        carry = (a < b);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_SHR: begin
        y     = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      default: ;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/risc_core_param.sv
// risc_core_param: parametrised multi-cycle RISC core
// (FETCH -> DECODE -> EXECUTE -> WRITE_BACK, HALT stops after EXECUTE).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   run                       start pulse, accepted in IDLE or HALTED (restarts at pc 0)
//   imem_we/waddr/wdata       program write, accepted in IDLE or HALTED
//   result, result_valid      last written-back value and its 1-cycle strobe
//   zero_flag, carry_flag     flags from the last ALU/shift op
//   halted, pc_out            HALTED status, current program counter
module risc_core_param
  import risc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [15:0]                   imem_wdata,
  output logic [DATA_W-1:0]             result,
  output logic                          result_valid,
  output logic                          zero_flag,
  output logic                          carry_flag,
  output logic                          halted,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc_out
);

  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int RW  = $clog2(NREGS);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] regs [NREGS];

  state_t            state, state_nx;
  logic [PCW-1:0]    pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] wb_val;
  logic              wb_zero, wb_carry;

  logic [3:0]        op;
  logic [RW-1:0]     rd_i, rs_i, rt_i;
  logic [DATA_W-1:0] rd_v, rs_v, rt_v;
  logic [DATA_W-1:0] imm_v, exec_val;
  logic [DAW-1:0]    d_addr;
  logic [PCW-1:0]    br_off, jmp_tgt;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero, alu_carry;
  logic              ctrl_open;
  logic [15:0]       unused_ir;

  // Register fields only use their low bits; the rest of ir is ignored.
  assign unused_ir = ir;

  assign op      = instr_op(ir);
  assign rd_i    = ir[8 +: RW];
  assign rs_i    = ir[4 +: RW];
  assign rt_i    = ir[0 +: RW];
  assign rd_v    = regs[rd_i];
  assign rs_v    = regs[rs_i];
  assign rt_v    = regs[rt_i];
  // Size casts zero-extend or truncate as the parameters require.
  assign imm_v   = DATA_W'(instr_imm8(ir));
  assign d_addr  = DAW'(rs_v);
  assign br_off  = PCW'(signed'(ir[3:0]));
  assign jmp_tgt = PCW'(instr_imm8(ir));

  assign ctrl_open = (state == S_IDLE) || (state == S_HALTED);
  assign halted    = (state == S_HALTED);
  assign pc_out    = pc;

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (rs_v),
    .b     (rt_v),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  always_comb begin
    case (op)
      OP_LD:   exec_val = dmem[d_addr];
      OP_ST:   exec_val = rt_v;
      OP_LDI:  exec_val = imm_v;
      default: exec_val = alu_y;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALTED: if (run) state_nx = S_FETCH;
      S_FETCH:          state_nx = S_DECODE;
      S_DECODE:         state_nx = S_EXECUTE;
      S_EXECUTE:        state_nx = (op == OP_HALT) ? S_HALTED : S_WRITE_BACK;
      S_WRITE_BACK:     state_nx = S_FETCH;
      default:          state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= '0;
      ir           <= '0;
      wb_val       <= '0;
      wb_zero      <= 1'b0;
      wb_carry     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: if (run) pc <= '0;
        S_FETCH: begin
          ir <= imem[pc];
          pc <= pc + PCW'(1);
        end
        S_EXECUTE: begin
          wb_val   <= exec_val;
          wb_zero  <= alu_zero;
          wb_carry <= alu_carry;
          // pc already points past this instruction
          if (op == OP_BEQ && rd_v == rs_v) pc <= pc + br_off;
          if (op == OP_JMP)                 pc <= jmp_tgt;
        end
        S_WRITE_BACK: begin
          if (writes_reg(op)) regs[rd_i] <= wb_val;
          if (writes_reg(op) || op == OP_ST) begin
            result       <= wb_val;
            result_valid <= 1'b1;
          end
          if (is_alu_op(op)) begin
            zero_flag  <= wb_zero;
            carry_flag <= wb_carry;
          end
        end
        default: ;
      endcase
    end
  end

  // Memories carry no reset; reset forces IDLE, so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (imem_we && ctrl_open) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (state == S_EXECUTE && op == OP_ST) dmem[d_addr] <= rt_v;
  end

endmodule

// File: tb/tb_risc_core_param.sv
// tb_risc_core_param: scoreboard bench for risc_core_param (DATA_W=8, NREGS=4, 16/16 depth).
// An instruction-level interpreter predicts every written-back result, the halt
// cycle count and the final pc; a monitor compares each result_valid strobe.
module tb_risc_core_param;

  logic        clk = 1'b0;
  logic        reset_n, run, imem_we;
  logic [3:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [7:0]  result;
  logic        result_valid, zero_flag, carry_flag, halted;
  logic [3:0]  pc_out;

  risc_core_param #(.DATA_W(8), .NREGS(4), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .result       (result),
    .result_valid (result_valid),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .halted       (halted),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit z;
    bit c;
    bit c_known;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] prog [16];
  int          m_regs [4];
  int          m_dmem [16];
  bit          m_z, m_c, m_ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] e3(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
  endfunction

  function automatic logic [15:0] ei(input int op, input int rd, input int imm);
    return {4'(op), 4'(rd), 8'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_z = 0; m_c = 0; m_ck = 1;
    sb.delete();
  endtask

  // Instruction-set interpreter over prog[]; pushes one entry per result strobe.
  task automatic model_run(input int max_instr, output int cycles, output int end_pc);
    int pc, op, rd, rs, rt, a, b, v, off;
    logic [15:0] w;
    bit done, push, alu;
    pc = 0; cycles = 0; done = 0;
    for (int n = 0; n < max_instr && !done; n++) begin
      w  = prog[pc];
      pc = (pc + 1) % 16;
      op = int'(w[15:12]); rd = int'(w[9:8]); rs = int'(w[5:4]); rt = int'(w[1:0]);
      a  = m_regs[rs]; b = m_regs[rt];
      push = 1; alu = 1; v = 0;
      case (op)
        0:  begin v = (a + b) % 256; m_c = (a + b) > 255; m_ck = 1; end
        1:  begin v = (a - b + 256) % 256; m_c = a < b; m_ck = 1; end
        2:  begin v = a & b; m_ck = 0; end
        3:  begin v = a | b; m_ck = 0; end
        9:  begin v = a ^ b; m_ck = 0; end
        10: begin v = (a * 2) % 256; m_c = a >= 128; m_ck = 1; end
        11: begin v = a / 2; m_c = (a % 2) == 1; m_ck = 1; end
        4:  begin v = m_dmem[a % 16]; alu = 0; end
        5:  begin v = b; m_dmem[a % 16] = b; alu = 0; end
        6:  begin v = int'(w[7:0]); alu = 0; end
        default: begin push = 0; alu = 0; end
      endcase
      if (op == 7 && m_regs[rd] == m_regs[rs]) begin
        off = (w[3:0] >= 4'd8) ? int'(w[3:0]) - 16 : int'(w[3:0]);
        pc  = (pc + off + 16) % 16;
      end
      if (op == 8) pc = int'(w[3:0]);
      if (alu) m_z = (v == 0);
      if (op != 4 && op != 5 && op != 6 && push) m_regs[rd] = v;
      if (op == 4 || op == 6) m_regs[rd] = v;
      if (push) sb.push_back('{res: v, z: m_z, c: m_c, c_known: m_ck});
      if (op == 15) begin cycles += 3; done = 1; end
      else cycles += 4;
    end
    end_pc = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = 4'(i); imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 16'hC000;
  endtask

  // full=0: issue run and return right after the start edge (caller takes over).
  task automatic run_prog(input int max_instr, input bit full, input bit poke);
    int exp_cyc, exp_pc, n;
    model_run(max_instr, exp_cyc, exp_pc);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    n = 0;
    if (poke) begin
      // DUT is in FETCH: this write must not overwrite the HALT at address 3
      imem_we = 1'b1; imem_waddr = 4'd3; imem_wdata = 16'h6000;
      @(posedge clk);
      #1 imem_we = 1'b0;
      n = 1;
    end
    if (!full) return;
    while (n < 3000) begin
      @(posedge clk);
      #1 n++;
      if (halted) break;
    end
    chk("halt_cycles", n, exp_cyc);
    chk("halt_pc", pc_out, exp_pc);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    if (!halted) do_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && result_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: result_valid with result %0h, expected no strobe", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero_flag", zero_flag, e.z);
        if (e.c_known) chk("carry_flag", carry_flag, e.c);
      end
    end
  end

  int op_tab [14] = '{0, 1, 2, 3, 9, 4, 5, 6, 6, 10, 11, 7, 8, 12};

  initial begin
    int k, lim, tgt;
    reset_n = 1'b0; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clear all of dmem with a counted loop (BEQ exit, BEQ -4 back edge)
    clear_prog();
    prog[0] = ei(6, 2, 1);
    prog[1] = ei(6, 3, 16);
    prog[2] = e3(5, 0, 0, 1);
    prog[3] = e3(0, 0, 0, 2);
    prog[4] = e3(7, 0, 3, 1);
    prog[5] = e3(7, 1, 1, 12);
    prog[6] = 16'hF000;
    for (int i = 0; i < 16; i++) m_dmem[i] = 0;
    load_prog();
    run_prog(500, 1, 0);

    // LDI/LDI/ADD/HALT, with an imem write attempted during FETCH
    clear_prog();
    prog[0] = ei(6, 0, 5);
    prog[1] = ei(6, 2, 3);
    prog[2] = e3(0, 1, 0, 2);
    prog[3] = 16'hF000;
    load_prog();
    run_prog(500, 1, 1);
    chk("halted_a", halted, 1);

    // ADD overflow to zero, JMP 0x13 -> 3, SUB borrow
    clear_prog();
    prog[0] = ei(6, 0, 8'h80);
    prog[1] = ei(8, 0, 8'h13);
    prog[2] = 16'hF000;
    prog[3] = e3(0, 1, 0, 0);
    prog[4] = ei(6, 2, 3);
    prog[5] = ei(6, 3, 5);
    prog[6] = e3(1, 1, 2, 3);
    prog[7] = 16'hF000;
    load_prog();
    run_prog(500, 1, 0);

    // Store then load back
    clear_prog();
    prog[0] = ei(6, 0, 5);
    prog[1] = ei(6, 2, 8'h0A);
    prog[2] = e3(5, 0, 0, 2);
    prog[3] = e3(4, 1, 0, 0);
    prog[4] = 16'hF000;
    load_prog();
    run_prog(500, 1, 0);

    // Reset during EXECUTE of a store; rerun shows dmem[5] untouched
    clear_prog();
    prog[0] = ei(6, 0, 5);
    prog[1] = e3(4, 1, 0, 0);
    prog[2] = ei(6, 2, 8'h33);
    prog[3] = e3(5, 0, 0, 2);
    prog[4] = 16'hF000;
    load_prog();
    run_prog(3, 0, 0);
    repeat (14) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_pc", pc_out, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_zero", zero_flag, 0);
    chk("mid_rst_sb", sb.size(), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_prog(500, 1, 0);

    // Wrap from pc 15 to 0, BEQ taken then not taken, JMP 0x1E -> 14
    do_reset();
    clear_prog();
    prog[0]  = e3(7, 1, 2, 1);
    prog[1]  = 16'hF000;
    prog[2]  = ei(8, 0, 8'h1E);
    prog[14] = ei(6, 1, 9);
    prog[15] = ei(6, 2, 8);
    load_prog();
    run_prog(500, 1, 0);

    // Random forward-only programs ending in HALT at address 15
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 15; i++) begin
        k = op_tab[$urandom_range(0, 13)];
        if (k == 7) begin
          lim = (14 - i) > 7 ? 7 : 14 - i;
          prog[i] = e3(7, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, lim));
        end else if (k == 8) begin
          tgt = $urandom_range(i + 1, 15);
          prog[i] = ei(8, $urandom_range(0, 15), ($urandom_range(0, 15) << 4) | tgt);
        end else if (k == 6) begin
          prog[i] = ei(6, $urandom_range(0, 15), $urandom_range(0, 255));
        end else begin
          prog[i] = e3(k, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        end
      end
      prog[15] = 16'hF000;
      load_prog();
      run_prog(500, 1, 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
